// File: rtl/i2s_tx_if.sv
// Stream handshake bundle: data moves on a clk edge where valid and ready are both 1.
interface Axis_If #(
    parameter int DWIDTH = 24
) ();
    logic [DWIDTH-1:0] data;
    logic              valid;
    logic              ready;

    modport Master (output data, output valid, input ready);
    modport Slave  (input data, input valid, output ready);
endinterface

// File: rtl/i2s_tx.sv
// I2S transmitter: mono 24-bit samples sent MSB first in both 32-bit slots of a 64-bclk frame.
// bclk/lrclk/sdata are all registered; data changes on bclk falls and is stable on rises.
module i2s_tx #(
    parameter int CLK_DIV = 4
) (
    input  logic  clk,
    input  logic  reset,
    Axis_If.Slave sample_in,
    output logic  bclk,
    output logic  lrclk,
    output logic  sdata,
    output logic  underrun
);

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    logic [7:0]  div_cnt;
    logic        div_wrap;
    logic        fall_evt;
    logic [5:0]  bit_cnt;
    logic [5:0]  bit_nxt;
    logic [4:0]  slot_nxt;
    logic        frame_load;
    logic        sdata_nxt;
    logic [23:0] frame_reg;
    logic [23:0] hold_reg;
    logic        full;
    logic        take;

    assign div_wrap   = (div_cnt == DIV_LAST);
    assign fall_evt   = div_wrap && bclk;
    assign bit_nxt    = bit_cnt + 6'd1;
    assign slot_nxt   = bit_nxt[4:0];
    assign frame_load = fall_evt && (bit_cnt == 6'd63);

    // ready depends only on the flag, so valid is never looked at while full.
    assign sample_in.ready = !full;
    assign take            = sample_in.valid && !full;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt <= 8'd0;
            bclk    <= 1'b0;
        end else if (div_wrap) begin
            div_cnt <= 8'd0;
            bclk    <= !bclk;
        end else begin
            div_cnt <= div_cnt + 8'd1;
        end
    end

    // Slot 0 and 25..31 are padding; slots 1..24 carry the sample MSB first.
    always_comb begin
        sdata_nxt = 1'b0;
        if (slot_nxt >= 5'd1 && slot_nxt <= 5'd24) begin
            sdata_nxt = frame_reg[5'd24 - slot_nxt];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bit_cnt <= 6'd0;
            lrclk   <= 1'b0;
            sdata   <= 1'b0;
        end else if (fall_evt) begin
            bit_cnt <= bit_nxt;
            lrclk   <= bit_nxt[5];
            sdata   <= sdata_nxt;
        end
    end

    // Frame load sees the pre-edge flag, so a sample arriving on the load edge waits a frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_reg <= 24'd0;
            hold_reg  <= 24'd0;
            full      <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            underrun <= frame_load && !full;
            if (frame_load) begin
                if (full) begin
                    frame_reg <= hold_reg;
                    full      <= 1'b0;
                end else begin
                    frame_reg <= 24'd0;
                end
            end
            if (take) begin
                hold_reg <= sample_in.data;
                full     <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_i2s_tx.sv
// Directed bench for i2s_tx at CLK_DIV = 4 (bclk period 8 clk, frame 512 clk).
module tb_i2s_tx;

    localparam logic [63:0] LR_EXP = 64'h00000000_FFFFFFFF;

    logic clk;
    logic reset;
    logic bclk;
    logic lrclk;
    logic sdata;
    logic underrun;
    int   total;
    int   bad;

    Axis_If #(.DWIDTH(24)) s_if ();

    i2s_tx #(.CLK_DIV(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .sample_in (s_if),
        .bclk      (bclk),
        .lrclk     (lrclk),
        .sdata     (sdata),
        .underrun  (underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] exp_frame(input logic [23:0] d);
        logic [31:0] h;
        h = {1'b0, d, 7'b0};
        return {h, h};
    endfunction

    task automatic do_reset();
        reset       = 1'b0;
        s_if.valid  = 1'b0;
        s_if.data   = 24'd0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
    endtask

    // Waits for the lrclk 1->0 transition, i.e. the frame wrap edge.
    task automatic wait_sync(output bit timed_out);
        logic prev;
        timed_out = 1'b1;
        prev = lrclk;
        for (int i = 0; i < 1200; i++) begin
            @(negedge clk);
            if (prev && !lrclk) begin
                timed_out = 1'b0;
                break;
            end
            prev = lrclk;
        end
    endtask

    // Records sdata/lrclk at the next 64 bclk rises (optionally after a frame wrap).
    task automatic capture(input bit sync, output bit timed_out, output logic ur_at_sync,
                           output logic [63:0] sd_bits, output logic [63:0] lr_bits,
                           output int ur_count);
        logic prevb;
        bit   got;
        timed_out  = 1'b0;
        ur_at_sync = 1'b0;
        ur_count   = 0;
        sd_bits    = '0;
        lr_bits    = '0;
        if (sync) begin
            wait_sync(timed_out);
            ur_at_sync = underrun;
        end
        if (!timed_out) begin
            for (int b = 0; b < 64; b++) begin
                got = 1'b0;
                prevb = bclk;
                for (int i = 0; i < 20; i++) begin
                    @(negedge clk);
                    if (underrun) ur_count++;
                    if (!prevb && bclk) begin
                        got = 1'b1;
                        break;
                    end
                    prevb = bclk;
                end
                if (!got) begin
                    timed_out = 1'b1;
                    break;
                end
                sd_bits[63-b] = sdata;
                lr_bits[63-b] = lrclk;
            end
        end
    endtask

    task automatic test_reset();
        int n;
        reset      = 1'b0;
        s_if.valid = 1'b0;
        s_if.data  = 24'd0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            total++;
            if ({bclk, lrclk, sdata, underrun, s_if.ready} !== 5'b00001) begin
                bad++;
                $display("FAIL reset_hold: got %b required 00001", {bclk, lrclk, sdata, underrun, s_if.ready});
            end
        end
        reset = 1'b1;
        n = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (bclk) begin
                n = i;
                break;
            end
        end
        total++;
        if (n !== 4) begin
            bad++;
            $display("FAIL first_bclk_rise: got %0d clk required 4", n);
        end
    endtask

    task automatic test_first_frame();
        bit to;
        logic ur;
        logic [63:0] sd, lr;
        int urc;
        do_reset();
        capture(1'b0, to, ur, sd, lr, urc);
        total++;
        if (to !== 1'b0 || sd !== 64'd0 || lr !== LR_EXP || urc !== 0) begin
            bad++;
            $display("FAIL first_frame: to=%b sd=%h lr=%h ur=%0d required to=0 sd=0 lr=%h ur=0", to, sd, lr, urc, LR_EXP);
        end
        wait_sync(to);
        total++;
        if (to !== 1'b0 || underrun !== 1'b1) begin
            bad++;
            $display("FAIL first_wrap_underrun: to=%b underrun=%b required to=0 underrun=1", to, underrun);
        end
    endtask

    task automatic test_underrun();
        bit to;
        logic ur;
        logic [63:0] sd, lr;
        int urc;
        int n;
        n = 0;
        for (int i = 1; i <= 600; i++) begin
            @(negedge clk);
            if (underrun) begin
                n = i;
                break;
            end
        end
        total++;
        if (n !== 512) begin
            bad++;
            $display("FAIL underrun_period: got %0d clk required 512", n);
        end
        capture(1'b0, to, ur, sd, lr, urc);
        total++;
        if (to !== 1'b0 || sd !== 64'd0 || lr !== LR_EXP || urc !== 0) begin
            bad++;
            $display("FAIL underrun_frame: to=%b sd=%h lr=%h ur=%0d required to=0 sd=0 lr=%h ur=0", to, sd, lr, urc, LR_EXP);
        end
    endtask

    task automatic test_single();
        bit to;
        logic ur;
        logic [63:0] sd, lr;
        int urc;
        do_reset();
        s_if.data  = 24'hA5C3F0;
        s_if.valid = 1'b1;
        @(negedge clk);
        s_if.valid = 1'b0;
        total++;
        if (s_if.ready !== 1'b0) begin
            bad++;
            $display("FAIL single_ready_drop: got %b required 0", s_if.ready);
        end
        repeat (200) @(negedge clk);
        total++;
        if (s_if.ready !== 1'b0) begin
            bad++;
            $display("FAIL single_ready_hold: got %b required 0", s_if.ready);
        end
        capture(1'b1, to, ur, sd, lr, urc);
        total++;
        if (to !== 1'b0 || ur !== 1'b0 || sd !== exp_frame(24'hA5C3F0) || lr !== LR_EXP || urc !== 0) begin
            bad++;
            $display("FAIL single_frame: to=%b ur=%b sd=%h urc=%0d required to=0 ur=0 sd=%h urc=0",
                     to, ur, sd, urc, exp_frame(24'hA5C3F0));
        end
        total++;
        if (s_if.ready !== 1'b1) begin
            bad++;
            $display("FAIL single_ready_back: got %b required 1", s_if.ready);
        end
    endtask

    task automatic test_back_to_back();
        bit to;
        logic ur;
        logic [63:0] sd, lr;
        int urc;
        int n;
        logic prev;
        bit found;
        bit stall_bad;
        do_reset();
        s_if.data  = 24'h000001;
        s_if.valid = 1'b1;
        n = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (!s_if.ready) begin
                n = i;
                break;
            end
        end
        total++;
        if (n !== 1) begin
            bad++;
            $display("FAIL bp_first_accept: got %0d clk required 1", n);
        end
        s_if.data = 24'h800000;
        found = 1'b0;
        stall_bad = 1'b0;
        prev = lrclk;
        for (int i = 0; i < 1200; i++) begin
            @(negedge clk);
            if (prev && !lrclk) begin
                found = 1'b1;
                break;
            end
            if (s_if.ready !== 1'b0) stall_bad = 1'b1;
            prev = lrclk;
        end
        total++;
        if (found !== 1'b1 || stall_bad !== 1'b0) begin
            bad++;
            $display("FAIL bp_stall: found=%b stall_bad=%b required found=1 stall_bad=0", found, stall_bad);
        end
        total++;
        if (s_if.ready !== 1'b1 || underrun !== 1'b0) begin
            bad++;
            $display("FAIL bp_wrap: ready=%b underrun=%b required ready=1 underrun=0", s_if.ready, underrun);
        end
        @(negedge clk);
        s_if.valid = 1'b0;
        total++;
        if (s_if.ready !== 1'b0) begin
            bad++;
            $display("FAIL bp_second_accept: ready=%b required 0", s_if.ready);
        end
        capture(1'b0, to, ur, sd, lr, urc);
        total++;
        if (to !== 1'b0 || sd !== exp_frame(24'h000001) || urc !== 0) begin
            bad++;
            $display("FAIL bp_frame1: to=%b sd=%h urc=%0d required to=0 sd=%h urc=0", to, sd, urc, exp_frame(24'h000001));
        end
        capture(1'b1, to, ur, sd, lr, urc);
        total++;
        if (to !== 1'b0 || ur !== 1'b0 || sd !== exp_frame(24'h800000) || urc !== 0) begin
            bad++;
            $display("FAIL bp_frame2: to=%b ur=%b sd=%h urc=%0d required to=0 ur=0 sd=%h urc=0",
                     to, ur, sd, urc, exp_frame(24'h800000));
        end
    endtask

    task automatic test_simultaneous();
        bit to;
        logic ur;
        logic [63:0] sd, lr;
        int urc;
        do_reset();
        wait_sync(to);
        total++;
        if (to !== 1'b0) begin
            bad++;
            $display("FAIL sim_first_sync: timed_out=%b required 0", to);
        end
        repeat (511) @(negedge clk);
        s_if.data  = 24'h7FFFFF;
        s_if.valid = 1'b1;
        @(negedge clk);
        s_if.valid = 1'b0;
        total++;
        if ({underrun, lrclk, s_if.ready} !== 3'b100) begin
            bad++;
            $display("FAIL sim_wrap_edge: underrun,lrclk,ready=%b required 100", {underrun, lrclk, s_if.ready});
        end
        capture(1'b0, to, ur, sd, lr, urc);
        total++;
        if (to !== 1'b0 || sd !== 64'd0 || urc !== 0) begin
            bad++;
            $display("FAIL sim_zero_frame: to=%b sd=%h urc=%0d required to=0 sd=0 urc=0", to, sd, urc);
        end
        capture(1'b1, to, ur, sd, lr, urc);
        total++;
        if (to !== 1'b0 || ur !== 1'b0 || sd !== exp_frame(24'h7FFFFF) || urc !== 0) begin
            bad++;
            $display("FAIL sim_next_frame: to=%b ur=%b sd=%h urc=%0d required to=0 ur=0 sd=%h urc=0",
                     to, ur, sd, urc, exp_frame(24'h7FFFFF));
        end
    endtask

    task automatic test_reset_mid();
        bit to;
        logic ur;
        logic [63:0] sd, lr;
        int urc;
        do_reset();
        s_if.data  = 24'h123456;
        s_if.valid = 1'b1;
        @(negedge clk);
        s_if.valid = 1'b0;
        repeat (322) @(negedge clk);
        total++;
        if (lrclk !== 1'b1 || s_if.ready !== 1'b0) begin
            bad++;
            $display("FAIL mid_precondition: lrclk=%b ready=%b required lrclk=1 ready=0", lrclk, s_if.ready);
        end
        #2 reset = 1'b0;
        #1;
        total++;
        if ({bclk, lrclk, sdata, underrun, s_if.ready} !== 5'b00001) begin
            bad++;
            $display("FAIL mid_async_reset: got %b required 00001", {bclk, lrclk, sdata, underrun, s_if.ready});
        end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        capture(1'b0, to, ur, sd, lr, urc);
        total++;
        if (to !== 1'b0 || sd !== 64'd0 || lr !== LR_EXP || urc !== 0) begin
            bad++;
            $display("FAIL mid_restart_frame: to=%b sd=%h lr=%h urc=%0d required to=0 sd=0 lr=%h urc=0", to, sd, lr, urc, LR_EXP);
        end
        capture(1'b1, to, ur, sd, lr, urc);
        total++;
        if (to !== 1'b0 || ur !== 1'b1 || sd !== 64'd0) begin
            bad++;
            $display("FAIL mid_discard: to=%b ur=%b sd=%h required to=0 ur=1 sd=0", to, ur, sd);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b0;
        s_if.valid = 1'b0;
        s_if.data  = 24'd0;
        test_reset();
        test_first_frame();
        test_underrun();
        test_single();
        test_back_to_back();
        test_simultaneous();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
